// File: rtl/main_fsm_if.sv
// Control/status bundle between the multicycle control FSM (master) and the
// datapath/memory side (slave).
interface main_fsm_if #(
  parameter int STATE_W = 4
);
  logic [6:0]         op;
  logic [2:0]         funct3;
  logic               zero;
  logic               mem_ready;
  logic               mem_req;
  logic               pc_write;
  logic               adr_src;
  logic               mem_write;
  logic               ir_write;
  logic [1:0]         result_src;
  logic [1:0]         alu_src_a;
  logic [1:0]         alu_src_b;
  logic [1:0]         imm_src;
  logic [1:0]         alu_op;
  logic               reg_write;
  logic               illegal;
  logic [STATE_W-1:0] state;

  modport master (
    input  op, funct3, zero, mem_ready,
    output mem_req, pc_write, adr_src, mem_write, ir_write, result_src,
           alu_src_a, alu_src_b, imm_src, alu_op, reg_write, illegal, state
  );

  modport slave (
    output op, funct3, zero, mem_ready,
    input  mem_req, pc_write, adr_src, mem_write, ir_write, result_src,
           alu_src_a, alu_src_b, imm_src, alu_op, reg_write, illegal, state
  );
endinterface

// File: rtl/main_fsm.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/mem/writeback.
// Optional ILLEGAL_TRAP_EN: unknown opcodes trap into a sticky ERROR state.
module main_fsm #(
  parameter int STATE_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  main_fsm_if.master bus
);

  localparam logic [STATE_W-1:0] S_FETCH    = STATE_W'(0);
  localparam logic [STATE_W-1:0] S_DECODE   = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_MEMADR   = STATE_W'(2);
  localparam logic [STATE_W-1:0] S_MEMREAD  = STATE_W'(3);
  localparam logic [STATE_W-1:0] S_MEMWB    = STATE_W'(4);
  localparam logic [STATE_W-1:0] S_MEMWRITE = STATE_W'(5);
  localparam logic [STATE_W-1:0] S_EXECR    = STATE_W'(6);
  localparam logic [STATE_W-1:0] S_EXECI    = STATE_W'(7);
  localparam logic [STATE_W-1:0] S_ALUWB    = STATE_W'(8);
  localparam logic [STATE_W-1:0] S_BRANCH   = STATE_W'(9);
  localparam logic [STATE_W-1:0] S_JAL      = STATE_W'(10);
  localparam logic [STATE_W-1:0] S_JALR     = STATE_W'(11);
  localparam logic [STATE_W-1:0] S_JALRLINK = STATE_W'(12);
  localparam logic [STATE_W-1:0] S_ERROR    = STATE_W'(13);

  logic [STATE_W-1:0] state_q, state_d;
  logic       mem_req_c, pc_write_c, mem_write_c, ir_write_c, reg_write_c;
  logic       adr_src_c;
  logic [1:0] result_src_c, alu_src_a_c, alu_src_b_c, alu_op_c;
  logic       unused_funct3;

  assign unused_funct3 = ^bus.funct3[2:1];

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          7'b0000011, 7'b0100011: state_d = S_MEMADR;
          7'b0110011:             state_d = S_EXECR;
          7'b0010011:             state_d = S_EXECI;
          7'b1100011:             state_d = S_BRANCH;
          7'b1101111:             state_d = S_JAL;
          7'b1100111:             state_d = S_JALR;
`ifdef ILLEGAL_TRAP_EN
          default:                state_d = S_ERROR;
`else
          default:                state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   state_d = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (bus.mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (bus.mem_ready) state_d = S_FETCH;
      S_EXECR,
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_JALR:     state_d = S_JALRLINK;
      S_JALRLINK: state_d = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
      S_ERROR:    state_d = S_ERROR;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    mem_req_c    = 1'b0;
    pc_write_c   = 1'b0;
    mem_write_c  = 1'b0;
    ir_write_c   = 1'b0;
    reg_write_c  = 1'b0;
    adr_src_c    = 1'b0;
    result_src_c = 2'b00;
    alu_src_a_c  = 2'b00;
    alu_src_b_c  = 2'b00;
    alu_op_c     = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_req_c    = 1'b1;
        alu_src_b_c  = 2'b10;
        result_src_c = 2'b10;
        ir_write_c   = bus.mem_ready;
        pc_write_c   = bus.mem_ready;
      end
      S_DECODE: begin
        alu_src_a_c = 2'b01;
        alu_src_b_c = 2'b01;
      end
      S_MEMADR, S_EXECI: begin
        alu_src_a_c = 2'b10;
        alu_src_b_c = 2'b01;
        alu_op_c    = (state_q == S_EXECI) ? 2'b10 : 2'b00;
      end
      S_MEMREAD: begin
        mem_req_c = 1'b1;
        adr_src_c = 1'b1;
      end
      S_MEMWB: begin
        result_src_c = 2'b01;
        reg_write_c  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req_c   = 1'b1;
        adr_src_c   = 1'b1;
        mem_write_c = 1'b1;
      end
      S_EXECR: begin
        alu_src_a_c = 2'b10;
        alu_op_c    = 2'b10;
      end
      S_ALUWB:    reg_write_c = 1'b1;
      S_BRANCH: begin
        alu_src_a_c = 2'b10;
        alu_op_c    = 2'b01;
        // beq takes on zero, bne on not-zero
        pc_write_c  = bus.zero ^ bus.funct3[0];
      end
      S_JAL: begin
        alu_src_a_c = 2'b01;
        alu_src_b_c = 2'b10;
        pc_write_c  = 1'b1;
      end
      S_JALR: begin
        alu_src_a_c  = 2'b10;
        alu_src_b_c  = 2'b01;
        result_src_c = 2'b10;
        pc_write_c   = 1'b1;
      end
      S_JALRLINK: begin
        alu_src_a_c  = 2'b01;
        alu_src_b_c  = 2'b10;
        result_src_c = 2'b10;
        reg_write_c  = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes are masked while reset is held so an abandoned access writes nothing
  assign bus.mem_req    = mem_req_c   & ~reset;
  assign bus.pc_write   = pc_write_c  & ~reset;
  assign bus.mem_write  = mem_write_c & ~reset;
  assign bus.ir_write   = ir_write_c  & ~reset;
  assign bus.reg_write  = reg_write_c & ~reset;
  assign bus.adr_src    = adr_src_c;
  assign bus.result_src = result_src_c;
  assign bus.alu_src_a  = alu_src_a_c;
  assign bus.alu_src_b  = alu_src_b_c;
  assign bus.alu_op     = alu_op_c;
  assign bus.state      = state_q;

  always_comb begin
    case (bus.op)
      7'b0100011: bus.imm_src = 2'b01;
      7'b1100011: bus.imm_src = 2'b10;
      7'b1101111: bus.imm_src = 2'b11;
      default:    bus.imm_src = 2'b00;
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  assign bus.illegal = (state_q == S_ERROR);
`else
  assign bus.illegal = 1'b0;
`endif

endmodule

// File: tb/tb_main_fsm.sv
// Scoreboard bench for main_fsm: stimulus pushes per-cycle expected outputs,
// a negedge monitor pops and compares.
module tb_main_fsm;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  main_fsm_if #(.STATE_W(4)) bus ();

  main_fsm #(.STATE_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  typedef struct {
    logic [20:0] v;
    string       tag;
  } exp_t;

  exp_t q[$];
  exp_t e;
  logic [20:0] act;
  int checks = 0;
  int failures = 0;

  // Packed as {state, mem_req, pc_write, ir_write, mem_write, reg_write,
  //            adr_src, result_src, alu_src_a, alu_src_b, alu_op, imm_src, illegal}
  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      act = {bus.state, bus.mem_req, bus.pc_write, bus.ir_write, bus.mem_write,
             bus.reg_write, bus.adr_src, bus.result_src, bus.alu_src_a,
             bus.alu_src_b, bus.alu_op, bus.imm_src, bus.illegal};
      checks++;
      if (act !== e.v) begin
        failures++;
        $display("FAIL %s: got state=%0d fields=%b, expected state=%0d fields=%b",
                 e.tag, act[20:17], act[16:0], e.v[20:17], e.v[16:0]);
      end else begin
        $display("ok   %s: state=%0d fields=%b", e.tag, act[20:17], act[16:0]);
      end
    end
  end

  task automatic expect_cyc(input string tag, input logic [3:0] st, input logic [4:0] stb,
                            input logic adr, input logic [1:0] rs, input logic [1:0] sa,
                            input logic [1:0] sb, input logic [1:0] ao, input logic [1:0] imm,
                            input logic ill);
    exp_t x;
    x.v = {st, stb, adr, rs, sa, sb, ao, imm, ill};
    x.tag = tag;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  // FETCH with mem_ready=1 and DECODE, the two common leading cycles
  task automatic fetch_decode(input string tag, input logic [1:0] imm);
    expect_cyc({tag, "_fetch"},  4'd0, 5'b11100, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, imm, 1'b0);
    expect_cyc({tag, "_decode"}, 4'd1, 5'b00000, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, imm, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.op = 7'b0100011;
    bus.funct3 = 3'b000;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    expect_cyc("rst_hold", 4'd0, 5'b00000, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0);

    // 1: sw, reset asserted for 2 cycles while MEMWRITE waits on memory
    reset = 1'b0;
    fetch_decode("sw", 2'b01);
    expect_cyc("sw_memadr", 4'd2, 5'b00000, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 2'b01, 1'b0);
    bus.mem_ready = 1'b0;
    expect_cyc("sw_memwr", 4'd5, 5'b10010, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0);
    reset = 1'b1;
    expect_cyc("sw_rst1", 4'd5, 5'b00000, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0);
    expect_cyc("sw_rst2", 4'd0, 5'b00000, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0);
    reset = 1'b0;
    expect_cyc("rel_fetch_wait", 4'd0, 5'b10000, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0);
    bus.mem_ready = 1'b1;

    // complete sw normally
    fetch_decode("sw2", 2'b01);
    expect_cyc("sw2_memadr", 4'd2, 5'b00000, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 2'b01, 1'b0);
    expect_cyc("sw2_memwr", 4'd5, 5'b10010, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0);

    // 2: R-type
    bus.op = 7'b0110011;
    fetch_decode("r", 2'b00);
    expect_cyc("r_exec", 4'd6, 5'b00000, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0);
    expect_cyc("r_aluwb", 4'd8, 5'b00001, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);

    // I-type ALU
    bus.op = 7'b0010011;
    fetch_decode("i", 2'b00);
    expect_cyc("i_exec", 4'd7, 5'b00000, 1'b0, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00, 1'b0);
    expect_cyc("i_aluwb", 4'd8, 5'b00001, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);

    // 3: lw with 3 wait cycles in MEMREAD
    bus.op = 7'b0000011;
    fetch_decode("lw", 2'b00);
    expect_cyc("lw_memadr", 4'd2, 5'b00000, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0);
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      expect_cyc("lw_memrd_wait", 4'd3, 5'b10000, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    bus.mem_ready = 1'b1;
    expect_cyc("lw_memrd_done", 4'd3, 5'b10000, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    expect_cyc("lw_memwb", 4'd4, 5'b00001, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);

    // 4: branches
    bus.op = 7'b1100011;
    bus.funct3 = 3'b000; bus.zero = 1'b1;
    fetch_decode("beq_t", 2'b10);
    expect_cyc("beq_taken", 4'd9, 5'b01000, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 2'b10, 1'b0);
    bus.zero = 1'b0;
    fetch_decode("beq_n", 2'b10);
    expect_cyc("beq_not", 4'd9, 5'b00000, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 2'b10, 1'b0);
    bus.funct3 = 3'b001;
    fetch_decode("bne_t", 2'b10);
    expect_cyc("bne_taken", 4'd9, 5'b01000, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 2'b10, 1'b0);
    bus.funct3 = 3'b000;

    // 5: jalr, then jal
    bus.op = 7'b1100111;
    fetch_decode("jalr", 2'b00);
    expect_cyc("jalr_exec", 4'd11, 5'b01000, 1'b0, 2'b10, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0);
    expect_cyc("jalr_link", 4'd12, 5'b00001, 1'b0, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0);
    bus.op = 7'b1101111;
    fetch_decode("jal", 2'b11);
    expect_cyc("jal_exec", 4'd10, 5'b01000, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00, 2'b11, 1'b0);
    expect_cyc("jal_aluwb", 4'd8, 5'b00001, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 1'b0);

    // 6: unrecognised opcode
    bus.op = 7'b1111111;
    fetch_decode("ill", 2'b00);
`ifdef ILLEGAL_TRAP_EN
    for (int i = 0; i < 10; i++)
      expect_cyc("ill_error", 4'd13, 5'b00000, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
    reset = 1'b1;
    expect_cyc("ill_rst", 4'd13, 5'b00000, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
    reset = 1'b0;
    expect_cyc("ill_recover", 4'd0, 5'b11100, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0);
`else
    expect_cyc("ill_nop", 4'd0, 5'b11100, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0);
`endif

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/main_fsm.md
Name: main_fsm

Overview:
Multicycle control FSM for the RV32I core. It sits directly upstream of the ALU decoder and drives its ALUOP input; the decoder combines that with funct3/funct7b5 to form ALUControl. The FSM decodes the opcode from the instruction register and sequences fetch, decode, execute, memory and writeback. It also produces all datapath mux selects and write strobes, and waits on a simple memory-ready handshake.

Parameters:
STATE_W, 4, width of state register and debug state port

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
op  in  7  instruction opcode field (Instr[6:0]) from instruction register
funct3  in  3  Instr[14:12]; only bit 0 used (branch polarity)
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes access this cycle
mem_req  out  1  memory access request
pc_write  out  1  PC register enable
adr_src  out  1  0 = PC, 1 = Result drives memory address
mem_write  out  1  memory write strobe
ir_write  out  1  instruction register / OldPC enable
result_src  out  2  00 ALUOut, 01 Data, 10 ALUResult
alu_src_a  out  2  00 PC, 01 OldPC, 10 RD1
alu_src_b  out  2  00 RD2, 01 ImmExt, 10 constant 4
imm_src  out  2  00 I, 01 S, 10 B, 11 J
alu_op  out  2  to ALU decoder: 00 add, 01 subtract, 10 funct-decoded
reg_write  out  1  register file write strobe
illegal  out  1  illegal-opcode flag (see Optional Feature)
state  out  STATE_W  current state, for debug/verification

Behaviour:
- Moore FSM: outputs decode only from state, except three signals. ir_write, pc_write in FETCH, and mem_write/exit from memory states also depend on mem_ready. pc_write in BRANCH depends on zero/funct3.
- Any rising edge with reset=1: state <= FETCH. While reset=1, all strobes (pc_write, ir_write, mem_write, reg_write, mem_req) are 0. After release, outputs are the FETCH values. Reset mid-instruction abandons it with no partial writes.
- imm_src is combinational from op: lw/jalr/I-ALU 00, sw 01, branch 10, jal 11, others 00.
- Every signal not listed for a state is 0.
- State encodings and per-state outputs:
  - FETCH(0): mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10. When mem_ready=1: ir_write=1, pc_write=1, next DECODE. Otherwise stay in FETCH with ir_write=pc_write=0.
  - DECODE(1): alu_src_a=01, alu_src_b=01, alu_op=00 (ALUOut <= branch/jal target). Next state by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 1100111 -> JALR
    - any other -> default (see Optional Feature)
  - MEMADR(2): alu_src_a=10, alu_src_b=01, alu_op=00. Next MEMREAD if op[5]=0, MEMWRITE if op[5]=1.
  - MEMREAD(3): mem_req=1, adr_src=1, result_src=00. Hold until mem_ready, then MEMWB.
  - MEMWB(4): result_src=01, reg_write=1. Next FETCH.
  - MEMWRITE(5): mem_req=1, adr_src=1, result_src=00, mem_write=1. mem_write stays high until mem_ready, then FETCH.
  - EXECUTER(6): alu_src_a=10, alu_src_b=00, alu_op=10. Next ALUWB.
  - EXECUTEI(7): alu_src_a=10, alu_src_b=01, alu_op=10. Next ALUWB.
  - ALUWB(8): result_src=00, reg_write=1. Next FETCH.
  - BRANCH(9): alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00. pc_write = zero XOR funct3[0] (beq/bne). Next FETCH.
  - JAL(10): alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1. Next ALUWB.
  - JALR(11): alu_src_a=10, alu_src_b=01, alu_op=00, result_src=10, pc_write=1. Next JALRLINK.
  - JALRLINK(12): alu_src_a=01, alu_src_b=10, alu_op=00, result_src=10, reg_write=1. Next FETCH.
  - ERROR(13): all strobes 0, illegal=1. Stays in ERROR until reset.
- Unused encodings 14–15 -> FETCH next cycle, all strobes 0.
- Cycle counts with mem_ready tied to 1:
  - lw 5, sw 4
  - R-type/I-ALU 4
  - branch 3
  - jal 4, jalr 4

Optional Feature:
Macro ILLEGAL_TRAP_EN.
- Defined: an unrecognised op in DECODE -> ERROR. illegal=1 from the next cycle and is sticky until reset.
- Undefined: an unrecognised op in DECODE -> FETCH, executing as a NOP with no writes. illegal is tied 0 and ERROR is unreachable.

Test Plan:
1. reset=1 for 2 cycles mid-MEMWRITE -> state=0 on the next edge, mem_write=0 during reset, FETCH outputs after release.
2. op=0110011, mem_ready=1 -> states 0,1,6,8,0. alu_op=10 in state 6; reg_write=1 only in state 8.
3. op=0000011, mem_ready low 3 cycles in MEMREAD -> state held at 3 with mem_req=1 for 4 cycles total, then MEMWB with result_src=01 and reg_write=1.
4. op=1100011, funct3=000, zero=1 -> pc_write=1 and alu_op=01 in BRANCH. Repeat with zero=0 -> pc_write=0. Repeat with funct3=001, zero=0 -> pc_write=1.
5. op=1100111 -> states 0,1,11,12,0. pc_write=1 in state 11 only; reg_write=1 with alu_src_a=01, alu_src_b=10 in state 12.
6. op=1111111 -> with ILLEGAL_TRAP_EN: state 13, illegal=1 held 10 cycles, no strobes. Without it: returns to state 0, illegal=0.
